move_controller: RTL and testbench

- Turn-based sequencer for the figure move logic.
- Takes board clicks, verifies piece ownership and queries the move logic for the selected square. It then latches and presents the highlight mask, validates the target click, and commits the move as a series of single-square board writes.
- Handles castling rook relocation, turn toggling and king-capture game over.
- Sits between the mouse/click decoder, the board register file and the move logic instance.

---
 rtl/chess_pkg.sv | 65 ++++++
 rtl/move_controller_if.sv | 46 ++++
 rtl/move_controller_castle_decode.sv | 48 ++++
 rtl/move_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_move_controller.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chess_pkg
// Purpose  : Shared definitions for the figure move controller: piece codes,
//            controller state encoding, castling square constants and the
//            side-ownership helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package chess_pkg;

  // Piece codes as stored in the board register file.
  localparam logic [3:0] EMPTY    = 4'h0;
  localparam logic [3:0] W_PAWN   = 4'h1;
  localparam logic [3:0] W_BISHOP = 4'h2;
  localparam logic [3:0] W_KNIGHT = 4'h3;
  localparam logic [3:0] W_ROOK   = 4'h4;
  localparam logic [3:0] W_QUEEN  = 4'h5;
  localparam logic [3:0] W_KING   = 4'h6;
  localparam logic [3:0] B_PAWN   = 4'h7;
  localparam logic [3:0] B_BISHOP = 4'h8;
  localparam logic [3:0] B_KNIGHT = 4'h9;
  localparam logic [3:0] B_ROOK   = 4'hA;
  localparam logic [3:0] B_QUEEN  = 4'hB;
  localparam logic [3:0] B_KING   = 4'hC;

  // Castling squares (index = row*8+col).
  localparam logic [5:0] W_KING_SQ       = 6'd60;
  localparam logic [5:0] W_KS_KING_DST   = 6'd62;
  localparam logic [5:0] W_QS_KING_DST   = 6'd58;
  localparam logic [5:0] W_KS_ROOK_SRC   = 6'd63;
  localparam logic [5:0] W_KS_ROOK_DST   = 6'd61;
  localparam logic [5:0] W_QS_ROOK_SRC   = 6'd56;
  localparam logic [5:0] W_QS_ROOK_DST   = 6'd59;
  localparam logic [5:0] B_KING_SQ       = 6'd4;
  localparam logic [5:0] B_KS_KING_DST   = 6'd6;
  localparam logic [5:0] B_QS_KING_DST   = 6'd2;
  localparam logic [5:0] B_KS_ROOK_SRC   = 6'd7;
  localparam logic [5:0] B_KS_ROOK_DST   = 6'd5;
  localparam logic [5:0] B_QS_ROOK_SRC   = 6'd0;
  localparam logic [5:0] B_QS_ROOK_DST   = 6'd3;

  // Controller states.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_QUERY    = 4'd1,
    S_SELECTED = 4'd2,
    S_CLR_SRC  = 4'd3,
    S_SET_DST  = 4'd4,
    S_ROOK_CLR = 4'd5,
    S_ROOK_SET = 4'd6,
    S_FINISH   = 4'd7,
    S_OVER     = 4'd8
  } ctrl_state_t;

  // True when 'code' is a piece belonging to 'side' (0 white, 1 black).
  function automatic logic is_own(input logic [3:0] code, input logic side);
    if (!side) begin
      return (code >= W_PAWN) && (code <= W_KING);
    end
    return (code >= B_PAWN) && (code <= B_KING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : move_controller_if
// Purpose  : Bundles the click, board, move-logic and board-write signals of
//            the move controller.
// Ports    : click_valid/click_pos (click decoder), board (register file
//            read), possible_moves (move logic), query_figure/query_position
//            (to move logic), highlight_mask, wr_en/wr_addr/wr_data (board
//            writes), turn, busy, move_done, reject, game_over.
//            Modport slave = the controller, master = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface move_controller_if;

  logic                   click_valid;
  logic [5:0]             click_pos;
  logic [7:0][7:0][3:0]   board;
  logic [63:0]            possible_moves;
  logic [3:0]             query_figure;
  logic [5:0]             query_position;
  logic [63:0]            highlight_mask;
  logic                   wr_en;
  logic [5:0]             wr_addr;
  logic [3:0]             wr_data;
  logic                   turn;
  logic                   busy;
  logic                   move_done;
  logic                   reject;
  logic                   game_over;

  modport slave (
    input  click_valid, click_pos, board, possible_moves,
    output query_figure, query_position, highlight_mask,
    output wr_en, wr_addr, wr_data,
    output turn, busy, move_done, reject, game_over
  );

  modport master (
    output click_valid, click_pos, board, possible_moves,
    input  query_figure, query_position, highlight_mask,
    input  wr_en, wr_addr, wr_data,
    input  turn, busy, move_done, reject, game_over
  );

endinterface
`default_nettype wire

// File: rtl/move_controller_castle_decode.sv
`default_nettype none
// ============================================================================
// Module   : castle_decode
// Purpose  : Recognises a castling king move and names the rook squares.
// Ports    : src_fig (moving figure), src_pos/dst_pos (king squares),
//            is_castle, rook_src, rook_dst (combinational results).
// Revision : 1.0 - initial release
// ============================================================================
module castle_decode
  import chess_pkg::*;
(
  input  logic [3:0] src_fig,
  input  logic [5:0] src_pos,
  input  logic [5:0] dst_pos,
  output logic       is_castle,
  output logic [5:0] rook_src,
  output logic [5:0] rook_dst
);

  always_comb begin
    is_castle = 1'b0;
    rook_src  = '0;
    rook_dst  = '0;
    if (src_fig == W_KING && src_pos == W_KING_SQ) begin
      if (dst_pos == W_KS_KING_DST) begin
        is_castle = 1'b1;
        rook_src  = W_KS_ROOK_SRC;
        rook_dst  = W_KS_ROOK_DST;
      end else if (dst_pos == W_QS_KING_DST) begin
        is_castle = 1'b1;
        rook_src  = W_QS_ROOK_SRC;
        rook_dst  = W_QS_ROOK_DST;
      end
    end else if (src_fig == B_KING && src_pos == B_KING_SQ) begin
      if (dst_pos == B_KS_KING_DST) begin
        is_castle = 1'b1;
        rook_src  = B_KS_ROOK_SRC;
        rook_dst  = B_KS_ROOK_DST;
      end else if (dst_pos == B_QS_KING_DST) begin
        is_castle = 1'b1;
        rook_src  = B_QS_ROOK_SRC;
        rook_dst  = B_QS_ROOK_DST;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
// Module   : move_controller
// Purpose  : Turn-based sequencer between the click decoder, the board
//            register file and the move logic. Selects a piece, queries and
//            latches its highlight mask, validates the target click and
//            commits the move as single-square board writes (with castling
//            rook relocation, turn toggling and king-capture game over).
// Ports    : clk, rst (synchronous, active high), bus (move_controller_if
//            slave modport: clicks, board, move-logic mask in; query, mask,
//            board writes, turn, busy, move_done, reject, game_over out).
// Params   : MASK_LATENCY - cycles from stable query to valid mask (1..7).
// Options  : MOVE_CONTROLLER_AUTO_QUEEN_EN - when defined, a pawn reaching
//            its last rank is written as a queen.
// Revision : 1.0 - initial release
// ============================================================================
module move_controller
  import chess_pkg::*;
#(
  parameter int MASK_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  move_controller_if.slave bus
);

  localparam logic [2:0] C_LAST_CNT = 3'(MASK_LATENCY - 1);

  ctrl_state_t r_state,     w_state_nxt;
  logic [5:0]  r_src_pos,   w_src_pos_nxt;
  logic [3:0]  r_src_fig,   w_src_fig_nxt;
  logic [5:0]  r_dst_pos,   w_dst_pos_nxt;
  logic [3:0]  r_cap_fig,   w_cap_fig_nxt;
  logic [2:0]  r_cnt,       w_cnt_nxt;
  logic [63:0] r_mask,      w_mask_nxt;
  logic        r_turn,      w_turn_nxt;
  logic        r_game_over, w_game_over_nxt;
  logic        r_reject,    w_reject_nxt;

  logic [63:0] w_own;
  logic [3:0]  w_click_fig;
  logic        w_click_own;
  logic        w_is_castle;
  logic [5:0]  w_rook_src;
  logic [5:0]  w_rook_dst;
  logic [3:0]  w_dst_code;
  logic [3:0]  w_rook_code;

  // Squares holding a piece of the side to move.
  for (genvar sq = 0; sq < 64; sq++) begin : g_own
    assign w_own[sq] = is_own(bus.board[sq / 8][sq % 8], r_turn);
  end

  assign w_click_fig = bus.board[bus.click_pos[5:3]][bus.click_pos[2:0]];
  assign w_click_own = is_own(w_click_fig, r_turn);
  assign w_rook_code = (r_src_fig == W_KING) ? W_ROOK : B_ROOK;

  castle_decode u_castle_decode (
    .src_fig   (r_src_fig),
    .src_pos   (r_src_pos),
    .dst_pos   (r_dst_pos),
    .is_castle (w_is_castle),
    .rook_src  (w_rook_src),
    .rook_dst  (w_rook_dst)
  );

`ifdef MOVE_CONTROLLER_AUTO_QUEEN_EN
  always_comb begin
    w_dst_code = r_src_fig;
    if (r_src_fig == W_PAWN && r_dst_pos[5:3] == 3'd0) begin
      w_dst_code = W_QUEEN;
    end else if (r_src_fig == B_PAWN && r_dst_pos[5:3] == 3'd7) begin
      w_dst_code = B_QUEEN;
    end
  end
`else
  assign w_dst_code = r_src_fig;
`endif

  assign bus.highlight_mask = r_mask;
  assign bus.turn           = r_turn;
  assign bus.game_over      = r_game_over;
  assign bus.reject         = r_reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_src_pos   <= '0;
      r_src_fig   <= EMPTY;
      r_dst_pos   <= '0;
      r_cap_fig   <= EMPTY;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_turn      <= 1'b0;
      r_game_over <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_src_pos   <= w_src_pos_nxt;
      r_src_fig   <= w_src_fig_nxt;
      r_dst_pos   <= w_dst_pos_nxt;
      r_cap_fig   <= w_cap_fig_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
      r_turn      <= w_turn_nxt;
      r_game_over <= w_game_over_nxt;
      r_reject    <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_src_pos_nxt      = r_src_pos;
    w_src_fig_nxt      = r_src_fig;
    w_dst_pos_nxt      = r_dst_pos;
    w_cap_fig_nxt      = r_cap_fig;
    w_cnt_nxt          = r_cnt;
    w_mask_nxt         = r_mask;
    w_turn_nxt         = r_turn;
    w_game_over_nxt    = r_game_over;
    w_reject_nxt       = 1'b0;
    bus.query_figure   = EMPTY;
    bus.query_position = '0;
    bus.wr_en          = 1'b0;
    bus.wr_addr        = '0;
    bus.wr_data        = EMPTY;
    bus.busy           = 1'b0;
    bus.move_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.click_valid) begin
          if (w_click_own) begin
            w_src_pos_nxt = bus.click_pos;
            w_src_fig_nxt = w_click_fig;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_QUERY;
          end else begin
            w_reject_nxt  = 1'b1;
          end
        end
      end

      S_QUERY: begin
        bus.busy           = 1'b1;
        bus.query_figure   = r_src_fig;
        bus.query_position = r_src_pos;
        if (r_cnt == C_LAST_CNT) begin
          // Own pieces and the source itself are never legal targets.
          w_mask_nxt  = bus.possible_moves & ~w_own & ~(64'd1 << r_src_pos);
          w_state_nxt = S_SELECTED;
        end else begin
          w_cnt_nxt   = r_cnt + 3'd1;
        end
      end

      S_SELECTED: begin
        if (bus.click_valid) begin
          if (bus.click_pos == r_src_pos) begin
            w_mask_nxt    = '0;
            w_state_nxt   = S_IDLE;
          end else if (w_click_own) begin
            w_src_pos_nxt = bus.click_pos;
            w_src_fig_nxt = w_click_fig;
            w_cnt_nxt     = '0;
            w_mask_nxt    = '0;
            w_state_nxt   = S_QUERY;
          end else if (r_mask[bus.click_pos]) begin
            w_dst_pos_nxt = bus.click_pos;
            w_cap_fig_nxt = w_click_fig;
            w_state_nxt   = S_CLR_SRC;
          end else begin
            w_reject_nxt  = 1'b1;
          end
        end
      end

      S_CLR_SRC: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = r_src_pos;
        bus.wr_data = EMPTY;
        w_state_nxt = S_SET_DST;
      end

      S_SET_DST: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = r_dst_pos;
        bus.wr_data = w_dst_code;
        w_state_nxt = w_is_castle ? S_ROOK_CLR : S_FINISH;
      end

      S_ROOK_CLR: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = w_rook_src;
        bus.wr_data = EMPTY;
        w_state_nxt = S_ROOK_SET;
      end

      S_ROOK_SET: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = w_rook_dst;
        bus.wr_data = w_rook_code;
        w_state_nxt = S_FINISH;
      end

      S_FINISH: begin
        bus.busy      = 1'b1;
        bus.move_done = 1'b1;
        w_mask_nxt    = '0;
        if (r_cap_fig == W_KING || r_cap_fig == B_KING) begin
          w_game_over_nxt = 1'b1;
          w_state_nxt     = S_OVER;
        end else begin
          w_turn_nxt      = ~r_turn;
          w_state_nxt     = S_IDLE;
        end
      end

      S_OVER: begin
        w_state_nxt = S_OVER;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_controller
// Purpose  : Self-checking bench for move_controller. Keeps its own board
//            register file, and predicts masks, write sequences, latency,
//            turn and game-over from the rules of play.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_controller;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_controller_if bus ();

  move_controller #(.MASK_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0][7:0][3:0] brd;
  assign bus.board = brd;

  int         checks   = 0;
  int         failures = 0;
  logic       m_turn;
  logic       m_over;
  logic [9:0] wr_q[$];
  int         n_done;
  int         n_rej;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] at(input logic [5:0] p);
    return brd[p[5:3]][p[2:0]];
  endfunction

  function automatic logic mine(input logic [3:0] c, input logic side);
    return side ? (c >= 4'h7 && c <= 4'hC) : (c >= 4'h1 && c <= 4'h6);
  endfunction

  function automatic logic [63:0] exp_mask(input logic [63:0] pm, input logic [5:0] src);
    logic [63:0] m;
    m = '0;
    for (int s = 0; s < 64; s++)
      if (pm[s] && !mine(at(6'(s)), m_turn) && s != int'(src)) m[s] = 1'b1;
    return m;
  endfunction

  // One clock: log any write presented this cycle, apply it to the board
  // model, then sample the outputs half a period after the edge.
  task automatic tick();
    logic       w;
    logic [5:0] a;
    logic [3:0] d;
    w = bus.wr_en;
    a = bus.wr_addr;
    d = bus.wr_data;
    if (w) wr_q.push_back({a, d});
    @(posedge clk);
    @(negedge clk);
    if (w) brd[a[5:3]][a[2:0]] = d;
    if (bus.move_done) n_done++;
    if (bus.reject) n_rej++;
  endtask

  task automatic click(input logic [5:0] p);
    bus.click_valid = 1'b1;
    bus.click_pos   = p;
    tick();
    bus.click_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.click_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_turn = 1'b0;
    m_over = 1'b0;
    wr_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_turn"}, bus.turn, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.move_done, 0);
    check({tag, "_reject"}, bus.reject, 0);
    check({tag, "_over"}, bus.game_over, 0);
    check({tag, "_mask"}, bus.highlight_mask, 0);
    check({tag, "_qfig"}, bus.query_figure, 0);
    check({tag, "_qpos"}, bus.query_position, 0);
  endtask

  task automatic clear_board();
    brd = '0;
  endtask

  task automatic init_board();
    logic [3:0] back_b[8];
    logic [3:0] back_w[8];
    back_b = '{4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};
    back_w = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
    brd = '0;
    for (int c = 0; c < 8; c++) begin
      brd[0][c] = back_b[c];
      brd[1][c] = 4'h7;
      brd[6][c] = 4'h1;
      brd[7][c] = back_w[c];
    end
  endtask

  // Click the source, follow the query phase and compare the latched mask.
  task automatic select(input logic [5:0] src, input logic [63:0] pm, output logic [63:0] mask);
    bus.possible_moves = pm;
    click(src);
    check("query_busy", bus.busy, 1);
    check("query_pos", bus.query_position, src);
    check("query_fig", bus.query_figure, at(src));
    repeat (LAT) tick();
    mask = exp_mask(pm, src);
    check("mask", bus.highlight_mask, mask);
    check("sel_busy", bus.busy, 0);
  endtask

  // Click the target of an already selected piece and check the commit.
  task automatic commit(input logic [5:0] src, input logic [5:0] dst);
    logic [9:0] exp_q[$];
    logic [3:0] fig, cap, put;
    logic [63:0] obs;
    int lat, sc, dc, row;
    bit castle;
    fig = at(src);
    cap = at(dst);
    put = fig;
`ifdef MOVE_CONTROLLER_AUTO_QUEEN_EN
    if (fig == 4'h1 && dst[5:3] == 3'd0) put = 4'h5;
    if (fig == 4'h7 && dst[5:3] == 3'd7) put = 4'hB;
`endif
    exp_q.push_back({src, 4'h0});
    exp_q.push_back({dst, put});
    // A king leaving its home square two files sideways drags the corner
    // rook on that side to the square it jumped over.
    sc  = int'(src[2:0]);
    dc  = int'(dst[2:0]);
    row = int'(src[5:3]);
    castle = ((fig == 4'h6 && row == 7) || (fig == 4'hC && row == 0)) && sc == 4 &&
             dst[5:3] == src[5:3] && (dc - sc == 2 || sc - dc == 2);
    if (castle) begin
      exp_q.push_back({6'(row * 8 + ((dc > sc) ? 7 : 0)), 4'h0});
      exp_q.push_back({6'(row * 8 + (sc + dc) / 2), (fig == 4'h6) ? 4'h4 : 4'hA});
    end
    wr_q.delete();
    n_done = 0;
    click(dst);
    lat = 1;
    while (n_done == 0 && lat < 12) begin
      tick();
      lat++;
    end
    check("done_seen", 64'(n_done), 1);
    check("latency", 64'(lat), castle ? 5 : 3);
    check("n_writes", 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < wr_q.size()) ? 64'(wr_q[i]) : '1;
      check($sformatf("write%0d", i), obs, 64'(exp_q[i]));
    end
    if (cap == 4'h6 || cap == 4'hC) m_over = 1'b1;
    else m_turn = ~m_turn;
    tick();
    check("done_pulse", bus.move_done, 0);
    check("turn", bus.turn, m_turn);
    check("game_over", bus.game_over, m_over);
    check("mask_clr", bus.highlight_mask, 0);
  endtask

  initial begin
    logic [63:0] msk, pm, kings;
    logic [5:0]  s, d;
    bit          found;

    rst = 1'b1;
    bus.click_valid    = 1'b0;
    bus.click_pos      = '0;
    bus.possible_moves = '0;
    init_board();
    @(negedge clk);
    do_reset();
    check_zero("reset");

    // Opponent piece on white's turn is refused with a single pulse.
    n_rej = 0;
    wr_q.delete();
    click(6'd12);
    check("rej_pulse", 64'(n_rej), 1);
    check("rej_nowr", 64'(wr_q.size()), 0);
    check("rej_busy", bus.busy, 0);
    tick();
    check("rej_one_cycle", bus.reject, 0);

    // Select, reselect another own pawn, then deselect it.
    select(6'd52, (64'd1 << 44) | (64'd1 << 36), msk);
    click(6'd51);
    check("reselect_qpos", bus.query_position, 51);
    check("reselect_mask_clr", bus.highlight_mask, 0);
    repeat (LAT) tick();
    check("reselect_mask", bus.highlight_mask, exp_mask(bus.possible_moves, 6'd51));
    click(6'd51);
    check("deselect_mask", bus.highlight_mask, 0);
    check("deselect_busy", bus.busy, 0);
    check("deselect_qfig", bus.query_figure, 0);

    // Pawn double step.
    select(6'd52, (64'd1 << 44) | (64'd1 << 36), msk);
    check("mask_e2e4", bus.highlight_mask, (64'd1 << 44) | (64'd1 << 36));
    commit(6'd52, 6'd36);

    // White king-side castling, then black queen-side castling.
    clear_board();
    brd[7][4] = 4'h6;
    brd[7][7] = 4'h4;
    brd[0][4] = 4'hC;
    brd[0][0] = 4'hA;
    do_reset();
    select(6'd60, 64'd1 << 62, msk);
    commit(6'd60, 6'd62);
    select(6'd4, 64'd1 << 2, msk);
    commit(6'd4, 6'd2);

    // King capture ends the game; later clicks do nothing.
    clear_board();
    brd[3][4] = 4'h5;
    brd[2][4] = 4'hC;
    brd[7][4] = 4'h6;
    do_reset();
    select(6'd28, (64'd1 << 20) | (64'd1 << 36), msk);
    commit(6'd28, 6'd20);
    wr_q.delete();
    n_rej = 0;
    click(6'd60);
    click(6'd20);
    repeat (4) tick();
    check("over_nowr", 64'(wr_q.size()), 0);
    check("over_norej", 64'(n_rej), 0);
    check("over_busy", bus.busy, 0);
    check("over_sticky", bus.game_over, 1);
    check("over_turn", bus.turn, 0);

    // Pawn reaching the last rank.
    clear_board();
    brd[1][0] = 4'h1;
    brd[7][4] = 4'h6;
    brd[0][7] = 4'hC;
    do_reset();
    select(6'd8, 64'd1, msk);
    commit(6'd8, 6'd0);

    // Reset while the destination write is on the bus.
    init_board();
    do_reset();
    select(6'd52, 64'd1 << 44, msk);
    click(6'd44);
    tick();
    check("mid_wr_en", bus.wr_en, 1);
    check("mid_wr_addr", bus.wr_addr, 44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midreset");
    wr_q.delete();
    repeat (3) tick();
    check("midreset_nowr", 64'(wr_q.size()), 0);

    // Random play from the initial position.
    init_board();
    do_reset();
    for (int it = 0; it < 40 && !m_over; it++) begin
      do s = 6'($urandom_range(0, 63)); while (mine(at(s), m_turn));
      n_rej = 0;
      wr_q.delete();
      click(s);
      check("rnd_idle_rej", 64'(n_rej), 1);
      check("rnd_idle_nowr", 64'(wr_q.size()), 0);

      do s = 6'($urandom_range(0, 63)); while (!mine(at(s), m_turn));
      kings = '0;
      for (int q = 0; q < 64; q++)
        if (at(6'(q)) == 4'h6 || at(6'(q)) == 4'hC) kings[q] = 1'b1;
      pm = {32'($urandom()), 32'($urandom())} & ~kings;
      select(s, pm, msk);
      if (msk == '0) begin
        click(s);
        check("rnd_deselect", bus.highlight_mask, 0);
        check("rnd_deselect_busy", bus.busy, 0);
      end else begin
        found = 1'b0;
        d = '0;
        for (int t = 0; t < 100 && !found; t++) begin
          d = 6'($urandom_range(0, 63));
          if (!mine(at(d), m_turn) && !msk[d] && d != s) found = 1'b1;
        end
        if (found) begin
          n_rej = 0;
          wr_q.delete();
          click(d);
          check("rnd_sel_rej", 64'(n_rej), 1);
          check("rnd_sel_nowr", 64'(wr_q.size()), 0);
          check("rnd_sel_keep", bus.highlight_mask, msk);
        end
        do d = 6'($urandom_range(0, 63)); while (!msk[d]);
        commit(s, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
